// File: rtl/cycle_check_pkg.sv
// Shared definitions for the uplink receive deframer.
// Header sync word, channel count, FSM states, header test.
package cycle_check_pkg;

  localparam logic [31:0] HEAD_DEF = 32'hadf90c00;
  localparam int          N_CH     = 4;

  typedef enum logic [1:0] {
    WAIT_HEAD = 2'd0,
    SEQ       = 2'd1,
    PAYLOAD   = 2'd2
  } state_e;

  function automatic logic is_head(
    input logic [63:0] w,
    input logic [31:0] head
  );
    return (w[63:32] == head)
        && (w[31:0] >= 32'd1)
        && (w[31:0] <= 32'd4);
  endfunction

endpackage

// File: rtl/cycle_seq_tracker.sv
// Per-channel frame counter continuity tracker.
// Holds last seen counters and saturating mismatch counts.
module cycle_seq_tracker
  import cycle_check_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               chk_stb,
  input  logic [1:0]                         chk_ch,
  input  logic [63:0]                        chk_val,
  output logic                               mismatch,
  output logic [N_CH-1:0][ERR_CNT_W-1:0]     err_cnt
);

  logic [N_CH-1:0][63:0]        last_q, last_d;
  logic [N_CH-1:0][ERR_CNT_W-1:0] cnt_q, cnt_d;

  // Counter wraps from all-ones to zero naturally.
  assign mismatch = chk_val != (last_q[chk_ch] + 64'd1);
  assign err_cnt  = cnt_q;

  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    if (chk_stb) begin
      last_d[chk_ch] = chk_val;
      if (mismatch && (cnt_q[chk_ch] != '1)) begin
        cnt_d[chk_ch] = cnt_q[chk_ch] + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
      cnt_q  <= '0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/cycle_check_in.sv
// Receive-side deframer: header search, counter check,
// and payload routing to four per-channel write strobes.
module cycle_check_in
  import cycle_check_pkg::*;
#(
  parameter int          FRAME_WORDS = 128,
  parameter logic [31:0] HEAD        = HEAD_DEF,
  parameter int          ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_valid,
  input  logic [63:0]          up_data,
  output logic [63:0]          ch_data,
  output logic [3:0]           ch_wr,
  output logic                 frame_done,
  output logic [1:0]           frame_ch,
  output logic [63:0]          frame_seq,
  output logic                 hdr_err,
  output logic                 seq_err,
  output logic                 len_err,
  output logic [ERR_CNT_W-1:0] seq_err_cnt1,
  output logic [ERR_CNT_W-1:0] seq_err_cnt2,
  output logic [ERR_CNT_W-1:0] seq_err_cnt3,
  output logic [ERR_CNT_W-1:0] seq_err_cnt4
);

  localparam int CW = $clog2(FRAME_WORDS + 1);
  localparam logic [CW-1:0] LAST_W = CW'(FRAME_WORDS - 1);

  state_e        state_q, state_d;
  logic [1:0]    ch_q, ch_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [63:0]   seqv_q, seqv_d;

  logic [63:0] ch_data_q, ch_data_d;
  logic [3:0]  ch_wr_q, ch_wr_d;
  logic        done_q, done_d;
  logic [1:0]  fch_q, fch_d;
  logic [63:0] fseq_q, fseq_d;
  logic        hdr_q, hdr_d;
  logic        seqe_q, seqe_d;
  logic        len_q, len_d;

  logic                           trk_stb;
  logic                           trk_mis;
  logic [N_CH-1:0][ERR_CNT_W-1:0] trk_cnt;

  logic head_ok;
  logic last_word;

  assign head_ok   = is_head(up_data, HEAD);
  assign last_word = wcnt_q == LAST_W;
  assign trk_stb   = (state_q == SEQ) && data_valid;

  cycle_seq_tracker #(
    .ERR_CNT_W (ERR_CNT_W)
  ) u_trk (
    .clk      (clk),
    .rst      (rst),
    .chk_stb  (trk_stb),
    .chk_ch   (ch_q),
    .chk_val  (up_data),
    .mismatch (trk_mis),
    .err_cnt  (trk_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_HEAD;
      ch_q      <= '0;
      wcnt_q    <= '0;
      seqv_q    <= '0;
      ch_data_q <= '0;
      ch_wr_q   <= '0;
      done_q    <= 1'b0;
      fch_q     <= '0;
      fseq_q    <= '0;
      hdr_q     <= 1'b0;
      seqe_q    <= 1'b0;
      len_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      wcnt_q    <= wcnt_d;
      seqv_q    <= seqv_d;
      ch_data_q <= ch_data_d;
      ch_wr_q   <= ch_wr_d;
      done_q    <= done_d;
      fch_q     <= fch_d;
      fseq_q    <= fseq_d;
      hdr_q     <= hdr_d;
      seqe_q    <= seqe_d;
      len_q     <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_HEAD: begin
        if (data_valid && head_ok) state_d = SEQ;
      end
      SEQ: begin
        state_d = data_valid ? PAYLOAD : WAIT_HEAD;
      end
      PAYLOAD: begin
        if (!data_valid || last_word) state_d = WAIT_HEAD;
      end
      default: state_d = WAIT_HEAD;
    endcase
  end

  always_comb begin
    ch_d      = ch_q;
    wcnt_d    = wcnt_q;
    seqv_d    = seqv_q;
    ch_data_d = ch_data_q;
    ch_wr_d   = '0;
    done_d    = 1'b0;
    fch_d     = fch_q;
    fseq_d    = fseq_q;
    hdr_d     = 1'b0;
    seqe_d    = 1'b0;
    len_d     = 1'b0;
    unique case (state_q)
      WAIT_HEAD: begin
        if (data_valid) begin
          if (head_ok) ch_d = up_data[1:0] - 2'd1;
          else         hdr_d = 1'b1;
        end
      end
      SEQ: begin
        if (data_valid) begin
          seqe_d = trk_mis;
          seqv_d = up_data;
          wcnt_d = '0;
        end else begin
          len_d = 1'b1;
        end
      end
      PAYLOAD: begin
        if (data_valid) begin
          ch_data_d     = up_data;
          ch_wr_d[ch_q] = 1'b1;
          wcnt_d        = wcnt_q + CW'(1);
          if (last_word) begin
            done_d = 1'b1;
            fch_d  = ch_q;
            fseq_d = seqv_q;
          end
        end else begin
          len_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ch_data      = ch_data_q;
  assign ch_wr        = ch_wr_q;
  assign frame_done   = done_q;
  assign frame_ch     = fch_q;
  assign frame_seq    = fseq_q;
  assign hdr_err      = hdr_q;
  assign seq_err      = seqe_q;
  assign len_err      = len_q;
  assign seq_err_cnt1 = trk_cnt[0];
  assign seq_err_cnt2 = trk_cnt[1];
  assign seq_err_cnt3 = trk_cnt[2];
  assign seq_err_cnt4 = trk_cnt[3];

endmodule

// File: tb/tb_cycle_check_in.sv
// Directed bench for cycle_check_in with a frame-level
// expectation model and per-cycle output comparison.
module tb_cycle_check_in;

  localparam int          FW   = 128;
  localparam int          EW   = 16;
  localparam logic [31:0] HDR  = 32'hadf90c00;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          data_valid = 1'b0;
  logic [63:0]   up_data = '0;
  logic [63:0]   ch_data;
  logic [3:0]    ch_wr;
  logic          frame_done;
  logic [1:0]    frame_ch;
  logic [63:0]   frame_seq;
  logic          hdr_err, seq_err, len_err;
  logic [EW-1:0] c1, c2, c3, c4;

  cycle_check_in #(
    .FRAME_WORDS (FW),
    .HEAD        (HDR),
    .ERR_CNT_W   (EW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_valid   (data_valid),
    .up_data      (up_data),
    .ch_data      (ch_data),
    .ch_wr        (ch_wr),
    .frame_done   (frame_done),
    .frame_ch     (frame_ch),
    .frame_seq    (frame_seq),
    .hdr_err      (hdr_err),
    .seq_err      (seq_err),
    .len_err      (len_err),
    .seq_err_cnt1 (c1),
    .seq_err_cnt2 (c2),
    .seq_err_cnt3 (c3),
    .seq_err_cnt4 (c4)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // expectation state, derived from what each frame is meant to do
  logic [3:0]  x_wr = '0;
  logic        x_done = 0, x_hdr = 0, x_seq = 0, x_len = 0;
  logic [63:0] e_data = '0, e_seq = '0;
  logic [1:0]  e_ch = '0;
  logic [63:0] e_last [4];
  int          e_cnt [4];

  // observed pulse tallies
  int n_wr [4];
  int n_done = 0, n_hdr = 0, n_seqe = 0, n_len = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input bit r, input bit v, input logic [63:0] d);
    @(negedge clk);
    rst = r;
    data_valid = v;
    up_data = d;
    @(posedge clk);
    #1;
    if (r) begin
      x_wr = '0; x_done = 0; x_hdr = 0; x_seq = 0; x_len = 0;
      e_data = '0; e_seq = '0; e_ch = '0;
      for (int k = 0; k < 4; k++) begin
        e_last[k] = '0;
        e_cnt[k] = 0;
      end
    end
    chk("ch_wr", 64'(ch_wr), 64'(x_wr));
    chk("ch_data", ch_data, e_data);
    chk("frame_done", 64'(frame_done), 64'(x_done));
    chk("frame_ch", 64'(frame_ch), 64'(e_ch));
    chk("frame_seq", frame_seq, e_seq);
    chk("hdr_err", 64'(hdr_err), 64'(x_hdr));
    chk("seq_err", 64'(seq_err), 64'(x_seq));
    chk("len_err", 64'(len_err), 64'(x_len));
    chk("cnt1", 64'(c1), 64'(e_cnt[0]));
    chk("cnt2", 64'(c2), 64'(e_cnt[1]));
    chk("cnt3", 64'(c3), 64'(e_cnt[2]));
    chk("cnt4", 64'(c4), 64'(e_cnt[3]));
    for (int k = 0; k < 4; k++) if (ch_wr[k]) n_wr[k]++;
    if (frame_done) n_done++;
    if (hdr_err) n_hdr++;
    if (seq_err) n_seqe++;
    if (len_err) n_len++;
    x_wr = '0; x_done = 0; x_hdr = 0; x_seq = 0; x_len = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, {$urandom, $urandom});
  endtask

  // n < FW truncates; cut selects reset instead of a valid drop
  task automatic send_frame(input int ch, input logic [63:0] seq,
                            input int n, input logic [63:0] base,
                            input bit cut);
    tick(0, 1, {HDR, 32'(ch)});
    x_seq = seq != (e_last[ch-1] + 64'd1);
    if (x_seq && e_cnt[ch-1] < (1 << EW) - 1) e_cnt[ch-1]++;
    e_last[ch-1] = seq;
    tick(0, 1, seq);
    for (int i = 0; i < n; i++) begin
      e_data = base + 64'(i);
      x_wr = 4'b0001 << (ch - 1);
      if (i == FW - 1) begin
        x_done = 1;
        e_ch = 2'(ch - 1);
        e_seq = seq;
      end
      tick(0, 1, base + 64'(i));
    end
    if (n < FW) begin
      if (cut) tick(1, 1, base + 64'(n));
      else begin
        x_len = 1;
        tick(0, 0, base + 64'(n));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      e_last[k] = '0;
      e_cnt[k] = 0;
      n_wr[k] = 0;
    end
    for (int i = 0; i < 3; i++)
      tick(1, 1'($urandom), {$urandom, $urandom});

    send_frame(1, 64'd1, FW, 64'd0, 0);
    chk("clean_wr_count", 64'(n_wr[0]), 64'd128);
    chk("clean_done", 64'(n_done), 64'd1);
    chk("clean_fseq", frame_seq, 64'd1);
    chk("clean_fch", 64'(frame_ch), 64'd0);
    chk("clean_noerr", 64'(n_seqe + n_hdr + n_len), 64'd0);
    idle(2);

    send_frame(3, 64'd1, FW, 64'h3000, 0);
    send_frame(3, 64'd2, FW, 64'h3100, 0);
    send_frame(3, 64'd4, FW, 64'h3200, 0);
    send_frame(3, 64'd5, FW, 64'h3300, 0);
    chk("seq_cnt3", 64'(c3), 64'd1);
    chk("seq_cnt1", 64'(c1), 64'd0);
    chk("seq_pulses", 64'(n_seqe), 64'd1);
    chk("seq_done", 64'(n_done), 64'd5);
    idle(1);

    x_hdr = 1;
    tick(0, 1, 64'hdeadbeef_00000001);
    x_hdr = 1;
    tick(0, 1, 64'hadf90c00_00000005);
    x_hdr = 1;
    tick(0, 1, 64'hadf90c00_00000000);
    send_frame(2, 64'd1, FW, {HDR, 32'd1}, 0);
    chk("hdr_pulses", 64'(n_hdr), 64'd3);
    chk("hdr_done", 64'(n_done), 64'd6);
    chk("hdr_fch", 64'(frame_ch), 64'd1);

    send_frame(4, 64'd1, 50, 64'h4000, 0);
    chk("trunc_wr", 64'(n_wr[3]), 64'd50);
    chk("trunc_len", 64'(n_len), 64'd1);
    chk("trunc_done", 64'(n_done), 64'd6);
    idle(1);
    send_frame(4, 64'd2, FW, 64'h4100, 0);
    chk("trunc_next", 64'(n_seqe), 64'd1);

    send_frame(1, 64'hffff_ffff_ffff_ffff, FW, 64'h1000, 0);
    send_frame(1, 64'd0, FW, 64'h1100, 0);
    chk("wrap_cnt1", 64'(c1), 64'd1);
    chk("wrap_pulses", 64'(n_seqe), 64'd2);

    send_frame(2, 64'd2, FW, 64'h2000, 0);
    send_frame(1, 64'd1, 60, 64'h1200, 1);
    chk("b2b_done", 64'(n_done), 64'd10);
    chk("rst_len", 64'(n_len), 64'd1);
    chk("rst_cnt3", 64'(c3), 64'd0);
    chk("rst_fseq", frame_seq, 64'd0);
    idle(1);
    send_frame(1, 64'd1, FW, 64'h1300, 0);
    chk("rst_resync", 64'(n_seqe), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cycle_check_in.md
Name: cycle_check_in

Overview:
- Receive-side deframer for the four-channel round-robin uplink stream (data_valid / up_data, 64-bit).
- Each frame on the stream is:
  - one header word {32'hadf90c00, channel number 1..4};
  - one 64-bit per-channel frame counter (first frame = 1);
  - FRAME_WORDS payload words.
- The block locates headers, checks per-channel frame-counter continuity (the "cycle check") and routes payload words to four per-channel write strobes for downstream FIFOs.
- It sits at the far end of the uplink, e.g. in the loopback/verification path or the host-side FPGA.

Parameters:
- FRAME_WORDS, 128, payload words per frame (threshold 1024 / 8).
- HEAD, 32'hadf90c00, header sync word in bits [63:32] of the header word.
- ERR_CNT_W, 16, width of the saturating per-channel error counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- data_valid  in  1  input word qualifier.
- up_data  in  64  input stream word.
- ch_data  out  64  registered payload word.
- ch_wr  out  4  one-hot write strobe; bit k means ch_data belongs to channel k+1.
- frame_done  out  1  one-cycle pulse when a frame completes with full length.
- frame_ch  out  2  channel index (0..3) of the last completed frame; holds until the next frame_done.
- frame_seq  out  64  frame counter of the last completed frame; holds until the next frame_done.
- hdr_err  out  1  one-cycle pulse: a valid word in WAIT_HEAD was not a legal header.
- seq_err  out  1  one-cycle pulse: frame counter discontinuity.
- len_err  out  1  one-cycle pulse: data_valid dropped inside a frame.
- seq_err_cnt1..seq_err_cnt4  out  ERR_CNT_W each  saturating seq_err count per channel.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state goes to WAIT_HEAD.
  - All outputs go to 0.
  - Expected-counter registers go to 0, so the first frame must carry 1.
  - Word counter goes to 0.
  - Reset mid-frame discards the frame; no frame_done or len_err is generated.
- Cycles with data_valid=0 are ignored in WAIT_HEAD.
- All outputs are registered; ch_wr and the error pulses appear 1 clk after the causing input word.
- WAIT_HEAD, on a valid word:
  - Legal header (up_data[63:32]==HEAD and up_data[31:0] in 1..4): latch ch = up_data[1:0]-1, go to SEQ.
  - Any other valid word: hdr_err pulse, stay in WAIT_HEAD.
- SEQ:
  - Next cycle data_valid=1: compare the word with last[ch]+1 (64-bit, wraps from all-ones to 0).
  - On mismatch: seq_err pulse, and seq_err_cntN increments, saturating at all-ones.
  - In all cases last[ch] <= received value (resync) and the counter is latched for frame_seq.
  - Then go to PAYLOAD with word counter = 0.
  - data_valid=0 in SEQ: len_err pulse, go to WAIT_HEAD.
- PAYLOAD:
  - Each valid word: ch_data <= up_data, ch_wr[ch] <= 1, word counter increments.
  - On the FRAME_WORDS-th word: frame_done pulse (same cycle as the final ch_wr), frame_ch and frame_seq update, go to WAIT_HEAD.
  - data_valid=0 before the last word: len_err pulse, go to WAIT_HEAD. Words already written remain written; frame_done is not asserted; last[ch] keeps the received counter.
- Back-to-back: a header in the cycle right after the last payload word must be accepted (zero gap).
- A payload word equal to a header pattern is treated as payload; there is no mid-frame resync.
- Only one of ch_wr[3:0] may be high in any cycle; all are low outside PAYLOAD.
- Error pulses are mutually exclusive by construction.

Decomposition:
- Package cycle_check_pkg holds:
  - HEAD and the channel count (4);
  - the state encoding WAIT_HEAD / SEQ / PAYLOAD;
  - a function for legal-header detection.
- Sub-module cycle_seq_tracker owns:
  - the four 64-bit last-counter registers;
  - the compare/increment logic;
  - the four saturating error counters.
- The top-level FSM drives cycle_seq_tracker with ch, the counter word and a strobe, and receives the mismatch flag.

Test Plan:
- Reset: hold rst=1 for 3 clk with random stream -> all outputs 0; after release, the first ch1 frame with counter 1 gives no seq_err.
- Clean frame: header 0xadf90c00_00000001, counter 1, payload 0..127 -> 128 ch_wr[0] pulses with ch_data 0..127 in order; one frame_done with the last word, frame_ch=0, frame_seq=1; no error pulses.
- Sequence error: ch3 frames with counters 1, 2, 4, 5 -> seq_err only on the third frame; seq_err_cnt3=1, other counters 0; all four frame_done pulses present.
- Bad header: valid word 0xdeadbeef_00000001, then 0xadf90c00_00000005 -> two hdr_err pulses, no ch_wr; a following legal ch2 frame is accepted.
- Truncation: ch4 frame with data_valid dropped after 50 payload words -> 50 ch_wr[3] pulses, one len_err, no frame_done; the next ch4 frame with counter 2 is clean.
- Back-to-back and reset: a ch2 frame immediately followed by a ch1 frame (zero gap) -> both frame_done pulses. Then rst=1 during the ch1 payload at word 60 -> ch_wr stops next cycle, all counters cleared, no len_err.
